sha256_padder: RTL and testbench
================================

Name: sha256_padder

Overview:
Streaming SHA-256 message pre-processor. It accepts raw message bytes as 32-bit big-endian words and emits complete 512-bit padded blocks: message bytes, then 0x80, then zeros, then the 64-bit bit length. It sits in front of the SHA-256 compression core, which consumes one 512-bit block at a time, MSB-first.

Parameters:
- LEN_W, 64, width of the message bit-length counter. Range 1..64. Bits above LEN_W in the length field are zero.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: asynchronous, active-high.
- in_valid, input, 1, input word valid.
- in_ready, output, 1, padder can accept a word.
- in_data, input, 32, message bytes; first byte in [31:24].
- in_bytes, input, 3, valid bytes in in_data, left-justified. Range 0..4; values above 4 are treated as 4.
- in_last, input, 1, this word ends the message.
- blk_valid, output, 1, blk_data holds a padded block.
- blk_ready, input, 1, consumer accepts the block.
- blk_data, output, 512, padded block; word0 in [511:480], word15 in [31:0].
- blk_last, output, 1, final block of the message.

Behaviour:
- Reset is asynchronous, active-high. While rst=1: state=FILL, word index widx=0, byte counter cleared, buffer cleared, blk_valid=0, blk_last=0, blk_data=0, in_ready=0.
- After reset is released, in_ready=1 in FILL.
- Reset asserted mid-message or mid-block discards all partial data; no block is emitted.
- Input transfer: in_valid & in_ready at posedge.
- Output transfer: blk_valid & blk_ready at posedge.
- in_ready = (state==FILL) & !rst. It is 0 whenever blk_valid=1.
- Byte masking: bytes beyond in_bytes are stored as zero.
- Length: byte counter += in_bytes on each accepted word. Length field = byte_count*8, modulo 2^LEN_W, big-endian in words 14..15.
- A word with in_bytes<4 and in_last=0 is a protocol error. Its valid bytes are stored and counted, and the word slot advances. Output is undefined-but-deterministic; benches do not check it.
- A word with in_bytes=0 and in_last=1 is legal and ends the message with no added data. This is the path for an empty message.
- FILL state:
  - Non-last word: stored at widx, widx++.
  - widx wraps 15->0 when the block is full: go to EMIT with blk_last=0.
- Last word: p = position of 0x80 = widx*4 + in_bytes, in bytes within the block.
  - p<=55: 0x80 at byte p, zeros, length in words 14..15. Go to EMIT, blk_last=1.
  - 56<=p<=63: 0x80 at byte p, zeros to end. Go to EMIT, blk_last=0, pending=EXTRA_LEN.
  - p==64 (last word fills the block exactly): go to EMIT, blk_last=0, pending=EXTRA_PAD.
- EMIT state:
  - blk_valid=1; blk_data and blk_last are registered and stable until the transfer.
  - blk_valid rises on the cycle after the input transfer that completed the block (latency 1).
- On transfer in EMIT:
  - pending=EXTRA_LEN: load an all-zero block with length in words 14..15, blk_last=1, stay in EMIT. blk_valid stays 1; the next block appears the cycle after the transfer.
  - pending=EXTRA_PAD: same as EXTRA_LEN, but word0=0x80000000.
  - Otherwise, if blk_last=1: clear byte counter, widx=0, go to FILL.
  - Otherwise (blk_last=0): go to FILL with widx=0, keeping the byte counter.
- Back-to-back messages are supported. A new message starts in FILL the cycle after the last-block transfer.
- The length counter wraps silently at 2^LEN_W; no error flag.

Test Plan:
- "abc": one word 0x61626300, in_bytes=3, last -> one block, word0=0x61626380, words1..14=0, word15=0x00000018, blk_last=1, blk_valid one cycle after accept.
- Empty message: in_bytes=0, last -> one block, word0=0x80000000, rest 0, length 0, blk_last=1.
- 55 bytes (13 full words + 3 bytes) -> single block, byte55=0x80, word15=0x000001B8, blk_last=1.
- 56 bytes -> block1 has word14=0x80000000, word15=0, blk_last=0. Block2 is all zero except word15=0x000001C0, blk_last=1.
- 64 bytes -> block1 = data, blk_last=0. Block2 word0=0x80000000, word15=0x00000200, blk_last=1.
- Backpressure: hold blk_ready=0 for 5 cycles -> blk_data/blk_last stable and in_ready=0. Then assert rst mid-second-message -> blk_valid=0 immediately; a following "abc" gives the same output as the first scenario.

Source files
------------

// File: rtl/sha256_padder.sv
// sha256_padder
// Streaming SHA-256 message pre-processor. Message bytes arrive as 32-bit
// big-endian words (first byte in [31:24]); the block leaves as complete
// 512-bit padded blocks: message bytes, 0x80, zeros, then the 64-bit message
// bit length in words 14..15. word0 sits in [511:480].
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   in_valid/ready  input word handshake
//   in_data         message bytes, left-justified
//   in_bytes        number of valid bytes in in_data (0..4, >4 treated as 4)
//   in_last         this word ends the message
//   blk_valid/ready output block handshake
//   blk_data        padded 512-bit block
//   blk_last        final block of the message
module sha256_padder #(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_bytes,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last
);

  typedef enum logic {
    S_FILL,
    S_EMIT
  } state_t;

  typedef enum logic [1:0] {
    P_NONE,
    P_EXTRA_LEN,
    P_EXTRA_PAD
  } pend_t;

  state_t             r_state, r_state_nx;
  pend_t              r_pend, r_pend_nx;
  logic [3:0]         r_widx, r_widx_nx;
  logic [LEN_W-1:0]   r_bcnt, r_bcnt_nx;
  logic [511:0]       r_blk, r_blk_nx;
  logic               r_last, r_last_nx;

  logic [2:0]         w_nb;
  logic [31:0]        w_base;
  logic [31:0]        w_pos;
  logic [LEN_W-1:0]   w_bcnt_acc;
  logic [511:0]       w_fill_blk;
  logic [511:0]       w_extra_blk;
  logic               w_fire_in;
  logic               w_fire_out;

  // Bit length = byte count * 8, truncated to LEN_W, zero-extended to 64.
  function automatic logic [63:0] len_field(input logic [LEN_W-1:0] bc);
    logic [LEN_W+2:0] bits;
    bits = {bc, 3'b000};
    return 64'(bits[LEN_W-1:0]);
  endfunction

  assign in_ready   = (r_state == S_FILL) & ~rst;
  assign blk_valid  = (r_state == S_EMIT);
  assign blk_data   = r_blk;
  assign blk_last   = r_last;

  assign w_fire_in  = in_valid & in_ready;
  assign w_fire_out = blk_valid & blk_ready;

  assign w_nb       = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign w_base     = {26'd0, r_widx, 2'b00};
  assign w_pos      = w_base + {29'd0, w_nb};
  assign w_bcnt_acc = r_bcnt + LEN_W'(w_nb);

  assign w_extra_blk = {(r_pend == P_EXTRA_PAD) ? 32'h8000_0000 : 32'h0,
                        416'd0, len_field(r_bcnt)};

  // Block image after accepting the current word. Bytes before the word slot
  // are kept; the slot takes the masked data; on a last word everything after
  // the data is the 0x80 marker followed by zeros, with the length on top
  // when it still fits in this block.
  always_comb begin
    w_fill_blk = r_blk;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i >= w_base) begin
        if (i < w_pos) begin
          w_fill_blk[511-8*i -: 8] = in_data[31-8*(i-w_base) -: 8];
        end else if (in_last) begin
          w_fill_blk[511-8*i -: 8] = (i == w_pos) ? 8'h80 : 8'h00;
        end else if (i < w_base + 32'd4) begin
          w_fill_blk[511-8*i -: 8] = 8'h00;
        end
      end
    end
    if (in_last && (w_pos <= 32'd55)) begin
      w_fill_blk[63:0] = len_field(w_bcnt_acc);
    end
  end

  always_comb begin
    r_state_nx = r_state;
    r_pend_nx  = r_pend;
    r_widx_nx  = r_widx;
    r_bcnt_nx  = r_bcnt;
    r_blk_nx   = r_blk;
    r_last_nx  = r_last;
    case (r_state)
      S_FILL: begin
        if (w_fire_in) begin
          r_blk_nx  = w_fill_blk;
          r_bcnt_nx = w_bcnt_acc;
          if (in_last) begin
            r_state_nx = S_EMIT;
            r_widx_nx  = '0;
            if (w_pos <= 32'd55) begin
              r_last_nx = 1'b1;
              r_pend_nx = P_NONE;
            end else if (w_pos <= 32'd63) begin
              r_last_nx = 1'b0;
              r_pend_nx = P_EXTRA_LEN;
            end else begin
              r_last_nx = 1'b0;
              r_pend_nx = P_EXTRA_PAD;
            end
          end else begin
            r_widx_nx = r_widx + 4'd1;
            if (r_widx == 4'd15) begin
              r_state_nx = S_EMIT;
              r_last_nx  = 1'b0;
              r_pend_nx  = P_NONE;
            end
          end
        end
      end
      S_EMIT: begin
        if (w_fire_out) begin
          if (r_pend != P_NONE) begin
            r_blk_nx  = w_extra_blk;
            r_last_nx = 1'b1;
            r_pend_nx = P_NONE;
          end else begin
            if (r_last) begin
              r_bcnt_nx = '0;
            end
            r_state_nx = S_FILL;
            r_widx_nx  = '0;
            r_last_nx  = 1'b0;
          end
        end
      end
      default: r_state_nx = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
      r_pend  <= P_NONE;
      r_widx  <= '0;
      r_bcnt  <= '0;
      r_blk   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= r_state_nx;
      r_pend  <= r_pend_nx;
      r_widx  <= r_widx_nx;
      r_bcnt  <= r_bcnt_nx;
      r_blk   <= r_blk_nx;
      r_last  <= r_last_nx;
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder
// Self-checking bench for sha256_padder: table of test-plan messages with
// hand-computed words, randomized messages against a standard SHA-256
// padding model, and hand-written latency / backpressure / reset sequences.
module tb_sha256_padder;

  typedef logic [7:0]   bq_t[$];
  typedef logic [511:0] blkq_t[$];

  typedef struct {
    int          len;
    int          nblk;
    logic [31:0] f14;
    logic [31:0] f15;
    logic [31:0] l0;
    logic [31:0] l13;
    logic [31:0] l14;
    logic [31:0] l15;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic [2:0]   in_bytes = '0;
  logic         in_last = 1'b0;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [511:0] blk_data;
  logic         blk_last;

  int    total = 0;
  int    bad = 0;
  int    rdy_mode = 0;
  blkq_t rx_d;
  bit    rx_l[$];

  sha256_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bytes  (in_bytes),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  // Consumer: 0 = stall, 1 = always ready, 2 = random ready.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       blk_ready = 1'b0;
      1:       blk_ready = 1'b1;
      default: blk_ready = ($urandom_range(0, 2) != 0);
    endcase
    if (blk_valid && blk_ready) begin
      rx_d.push_back(blk_data);
      rx_l.push_back(blk_last);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Standard SHA-256 padding on a byte list.
  function automatic blkq_t model(input bq_t msg);
    bq_t          q;
    blkq_t        r;
    logic [63:0]  bl;
    logic [511:0] b;
    q = msg;
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) q.push_back(bl[8*k +: 8]);
    for (int j = 0; j < q.size() / 64; j++) begin
      b = '0;
      for (int k = 0; k < 64; k++) b[511-8*k -: 8] = q[64*j+k];
      r.push_back(b);
    end
    return r;
  endfunction

  // Call right after a negedge; returns one negedge after the accept edge.
  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int cnt = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_bytes = nb;
    in_last  = last;
    while (!in_ready && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_wait: got 0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_msg(input bq_t msg, input bit rnd);
    int          n;
    int          pos;
    int          nb;
    bit          trail;
    logic [31:0] d;
    logic [2:0]  fld;
    n = msg.size();
    pos = 0;
    trail = rnd && (n > 0) && (n % 4 == 0) && ($urandom_range(0, 3) == 0);
    if (n == 0) send_word($urandom, 3'd0, 1'b1);
    while (pos < n) begin
      nb = (n - pos > 4) ? 4 : n - pos;
      for (int b = 0; b < 4; b++) d[31-8*b -: 8] = (b < nb) ? msg[pos+b] : 8'($urandom);
      fld = 3'(nb);
      if (nb == 4 && rnd && $urandom_range(0, 3) == 0) fld = 3'($urandom_range(5, 7));
      if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_word(d, fld, (pos + nb == n) && !trail);
      pos += nb;
    end
    if (trail) send_word($urandom, 3'd0, 1'b1);
  endtask

  task automatic wait_rx(input int n);
    int cnt = 0;
    while (rx_d.size() < n && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    if (rx_d.size() < n) begin
      total++;
      bad++;
      $display("FAIL blk_wait: got %0d blocks expected %0d", rx_d.size(), n);
    end
  endtask

  task automatic run_msg(input bq_t msg, input bit rnd);
    blkq_t exp;
    exp = model(msg);
    rx_d.delete();
    rx_l.delete();
    rdy_mode = rnd ? 2 : 1;
    send_msg(msg, rnd);
    wait_rx(exp.size());
    repeat (3) @(negedge clk);
    chk("blk_count", rx_d.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_d.size(); i++) begin
      chk("blk_data", rx_d[i], exp[i]);
      chk("blk_last", rx_l[i], (i == exp.size() - 1));
    end
  endtask

  function automatic bq_t pattern(input int len);
    bq_t m;
    for (int i = 0; i < len; i++) m.push_back(8'h61 + 8'(i % 26));
    return m;
  endfunction

  initial begin
    vec_t         vt[6];
    bq_t          m;
    logic [511:0] f;
    logic [511:0] l;
    logic [511:0] abc_blk;
    int           sel;
    int           len;

    vt[0] = '{3,   1, 32'h0,        32'h18,       32'h61626380, 32'h0,        32'h0,        32'h18};
    vt[1] = '{0,   1, 32'h0,        32'h0,        32'h80000000, 32'h0,        32'h0,        32'h0};
    vt[2] = '{55,  1, 32'h0,        32'h1B8,      32'h61626364, 32'h61626380, 32'h0,        32'h1B8};
    vt[3] = '{56,  2, 32'h80000000, 32'h0,        32'h0,        32'h0,        32'h0,        32'h1C0};
    vt[4] = '{64,  2, 32'h65666768, 32'h696A6B6C, 32'h80000000, 32'h0,        32'h0,        32'h200};
    vt[5] = '{119, 2, 32'h65666768, 32'h696A6B6C, 32'h6D6E6F70, 32'h6D6E6F80, 32'h0,        32'h3B8};
    abc_blk = {32'h61626380, 448'd0, 32'h00000018};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_blk_valid", blk_valid, 1'b0);
    chk("rst_blk_last", blk_last, 1'b0);
    chk("rst_blk_data", blk_data, 512'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Table-driven test-plan messages
    foreach (vt[t]) begin
      run_msg(pattern(vt[t].len), 1'b0);
      chk("tbl_nblk", rx_d.size(), vt[t].nblk);
      if (rx_d.size() > 0) begin
        f = rx_d[0];
        l = rx_d[rx_d.size()-1];
        chk("tbl_first_w14", f[63:32], vt[t].f14);
        chk("tbl_first_w15", f[31:0], vt[t].f15);
        chk("tbl_last_w0", l[511:480], vt[t].l0);
        chk("tbl_last_w13", l[95:64], vt[t].l13);
        chk("tbl_last_w14", l[63:32], vt[t].l14);
        chk("tbl_last_w15", l[31:0], vt[t].l15);
      end
    end

    // Randomized messages, clustered around the padding boundaries
    for (int r = 0; r < 40; r++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       len = $urandom_range(0, 200);
        1:       len = $urandom_range(52, 68);
        2:       len = $urandom_range(116, 132);
        default: len = $urandom_range(0, 8);
      endcase
      m.delete();
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      run_msg(m, 1'b1);
    end

    // Latency and backpressure on "abc"
    rx_d.delete();
    rx_l.delete();
    rdy_mode = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h61626300;
    in_bytes = 3'd3;
    in_last  = 1'b1;
    chk("abc_in_ready", in_ready, 1'b1);
    chk("abc_valid_before", blk_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abc_valid_latency", blk_valid, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_data", blk_data, abc_blk);
      chk("bp_last", blk_last, 1'b1);
      chk("bp_valid", blk_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    rdy_mode = 1;
    wait_rx(1);
    repeat (2) @(negedge clk);
    chk("bp_count", rx_d.size(), 1);
    if (rx_d.size() > 0) chk("bp_rx", rx_d[0], abc_blk);
    chk("bp_valid_after", blk_valid, 1'b0);

    // Reset while a full block is waiting for the consumer
    rx_d.delete();
    rx_l.delete();
    rdy_mode = 0;
    m = pattern(67);
    for (int w = 0; w < 16; w++)
      send_word({m[4*w], m[4*w+1], m[4*w+2], m[4*w+3]}, 3'd4, 1'b0);
    chk("mid_blk_valid", blk_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", blk_valid, 1'b0);
    chk("rst_async_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_discard", rx_d.size(), 0);
    run_msg(pattern(3), 1'b0);
    if (rx_d.size() > 0) chk("abc_after_rst", rx_d[0], abc_blk);

    // Reset while a block is partially filled
    rdy_mode = 0;
    for (int w = 0; w < 5; w++) send_word(32'hDEADBEEF, 3'd4, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("partial_rst_valid", blk_valid, 1'b0);
    run_msg(pattern(3), 1'b0);
    if (rx_d.size() > 0) chk("abc_after_partial", rx_d[0], abc_blk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
